// File: rtl/je6850_txarb_if.sv
// je6850_txarb_if: requester handshake plus ACIA CPU-side bus of the je6850 TX arbiter.
// The master modport is the arbiter's view, the slave modport the requesters'/ACIA's view.
interface je6850_txarb_if #(
    parameter int N = 2
);
    logic [N-1:0]   REQ;
    logic [8*N-1:0] DATA;
    logic [N-1:0]   ACK;
    logic [N-1:0]   ERR;
    logic           BUSY;
    logic           ACIA_E;
    logic [2:0]     ACIA_CS;
    logic           ACIA_RS;
    logic           ACIA_RNW;
    logic [7:0]     ACIA_DI;
    logic [7:0]     ACIA_DO;

    modport master (
        input  REQ, DATA, ACIA_DO,
        output ACK, ERR, BUSY, ACIA_E, ACIA_CS, ACIA_RS, ACIA_RNW, ACIA_DI
    );

    modport slave (
        output REQ, DATA, ACIA_DO,
        input  ACK, ERR, BUSY, ACIA_E, ACIA_CS, ACIA_RS, ACIA_RNW, ACIA_DI
    );
endinterface

// File: rtl/je6850_txarb.sv
// je6850_txarb: sole bus master of one je6850 ACIA. Runs the control-register init
// sequence after reset, then shares the transmitter among N requesters round-robin,
// polling TDRE before every TDR write. All bus and handshake outputs are registered.
// Optional feature macro: JE6850_TXARB_TIMEOUT_EN (poll timeout with ERR pulse).
module je6850_txarb #(
    parameter int          N           = 2,
    parameter logic [7:0]  CTRL_INIT   = 8'h96,
    parameter int          POST_WR_GAP = 4,
    parameter int          POLL_GAP    = 2,
    parameter logic [15:0] TIMEOUT     = 16'hFFFF
) (
    input logic            CLK,
    input logic            RESET,
    je6850_txarb_if.master bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int GW = 8;

    typedef enum logic [2:0] {
        INIT_MR   = 3'd0,
        INIT_CFG  = 3'd1,
        IDLE      = 3'd2,
        POLL      = 3'd3,
        CHECK     = 3'd4,
        POLL_WAIT = 3'd5,
        WRITE     = 3'd6,
        GAP       = 3'd7
    } state_t;

    state_t          state_r;
    logic            phase_r;     // second half of two-cycle states
    logic [PW-1:0]   ptr_r;       // round-robin pointer
    logic [PW-1:0]   grant_r;     // locked grant
    logic [7:0]      data_r;      // latched byte of the granted requester
    logic            tdre_r;      // TDRE sampled at the end of S+1
    logic [GW-1:0]   gapCnt_r;
    logic [PW-1:0]   pick_s;
`ifdef JE6850_TXARB_TIMEOUT_EN
    logic [15:0]     pollCnt_r;
`endif

    // First set request at or after the pointer, wrapping N-1 -> 0
    function automatic logic [PW-1:0] rrPick(input logic [N-1:0] req, input logic [PW-1:0] ptr);
        logic [PW-1:0] pick;
        logic          found;
        int            idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                pick  = PW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Pointer successor modulo N
    function automatic logic [PW-1:0] rrNext(input logic [PW-1:0] g);
        if (int'(g) >= N - 1) begin
            return {PW{1'b0}};
        end else begin
            return g + PW'(1);
        end
    endfunction

    // One-hot pulse vector for the granted requester
    function automatic logic [N-1:0] oneHot(input logic [PW-1:0] g);
        logic [N-1:0] v;
        v    = {N{1'b0}};
        v[g] = 1'b1;
        return v;
    endfunction

    // Round-robin candidate for the next grant, evaluated every cycle
    always_comb begin
        pick_s = rrPick(bus.REQ, ptr_r);
    end

    // Init sequence, grant, TDRE polling, TDR write and post-write gap
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r      <= INIT_MR;
            phase_r      <= 1'b0;
            ptr_r        <= {PW{1'b0}};
            grant_r      <= {PW{1'b0}};
            data_r       <= 8'h00;
            tdre_r       <= 1'b0;
            gapCnt_r     <= {GW{1'b0}};
            bus.ACK      <= {N{1'b0}};
            bus.ERR      <= {N{1'b0}};
            bus.BUSY     <= 1'b1;
            bus.ACIA_E   <= 1'b0;
            bus.ACIA_CS  <= 3'b000;
            bus.ACIA_RS  <= 1'b0;
            bus.ACIA_RNW <= 1'b1;
            bus.ACIA_DI  <= 8'h00;
`ifdef JE6850_TXARB_TIMEOUT_EN
            pollCnt_r    <= 16'd0;
`endif
        end else begin
            bus.ACK <= {N{1'b0}};
            bus.ERR <= {N{1'b0}};
            case (state_r)
                INIT_MR: begin
                    if (!phase_r) begin
                        // master reset write to the control register
                        bus.ACIA_E   <= 1'b1;
                        bus.ACIA_CS  <= 3'b011;
                        bus.ACIA_RS  <= 1'b0;
                        bus.ACIA_RNW <= 1'b0;
                        bus.ACIA_DI  <= 8'h03;
                        phase_r      <= 1'b1;
                    end else begin
                        bus.ACIA_E   <= 1'b0;
                        bus.ACIA_CS  <= 3'b000;
                        bus.ACIA_RNW <= 1'b1;
                        phase_r      <= 1'b0;
                        state_r      <= INIT_CFG;
                    end
                end
                INIT_CFG: begin
                    if (!phase_r) begin
                        bus.ACIA_E   <= 1'b1;
                        bus.ACIA_CS  <= 3'b011;
                        bus.ACIA_RS  <= 1'b0;
                        bus.ACIA_RNW <= 1'b0;
                        bus.ACIA_DI  <= CTRL_INIT;
                        phase_r      <= 1'b1;
                    end else begin
                        bus.ACIA_E   <= 1'b0;
                        bus.ACIA_CS  <= 3'b000;
                        bus.ACIA_RNW <= 1'b1;
                        bus.ACIA_DI  <= 8'h00;
                        bus.BUSY     <= 1'b0;
                        phase_r      <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                IDLE: begin
                    if (bus.REQ != {N{1'b0}}) begin
                        grant_r      <= pick_s;
                        data_r       <= bus.DATA[8*int'(pick_s) +: 8];
                        bus.BUSY     <= 1'b1;
                        // status read strobe happens in POLL
                        bus.ACIA_E   <= 1'b1;
                        bus.ACIA_CS  <= 3'b011;
                        bus.ACIA_RS  <= 1'b0;
                        bus.ACIA_RNW <= 1'b1;
                        state_r      <= POLL;
`ifdef JE6850_TXARB_TIMEOUT_EN
                        pollCnt_r    <= 16'd0;
`endif
                    end else begin
                        bus.BUSY <= 1'b0;
                    end
                end
                POLL: begin
                    bus.ACIA_E  <= 1'b0;
                    bus.ACIA_CS <= 3'b000;
                    phase_r     <= 1'b0;
                    state_r     <= CHECK;
                end
                CHECK: begin
                    if (!phase_r) begin
                        // S+1: the ACIA presents the status registered at S
                        tdre_r  <= bus.ACIA_DO[1];
                        phase_r <= 1'b1;
                    end else if (tdre_r) begin
                        bus.ACIA_E   <= 1'b1;
                        bus.ACIA_CS  <= 3'b011;
                        bus.ACIA_RS  <= 1'b1;
                        bus.ACIA_RNW <= 1'b0;
                        bus.ACIA_DI  <= data_r;
                        bus.ACK      <= oneHot(grant_r);
                        ptr_r        <= rrNext(grant_r);
                        phase_r      <= 1'b0;
                        state_r      <= WRITE;
                    end else begin
                        phase_r <= 1'b0;
`ifdef JE6850_TXARB_TIMEOUT_EN
                        if (pollCnt_r + 16'd1 == TIMEOUT) begin
                            // give up on this byte and let the next requester in
                            bus.ERR  <= oneHot(grant_r);
                            ptr_r    <= rrNext(grant_r);
                            bus.BUSY <= 1'b0;
                            state_r  <= IDLE;
                        end else if (POLL_GAP == 0) begin
                            pollCnt_r    <= pollCnt_r + 16'd1;
                            bus.ACIA_E   <= 1'b1;
                            bus.ACIA_CS  <= 3'b011;
                            bus.ACIA_RS  <= 1'b0;
                            bus.ACIA_RNW <= 1'b1;
                            state_r      <= POLL;
                        end else begin
                            pollCnt_r <= pollCnt_r + 16'd1;
                            gapCnt_r  <= GW'(POLL_GAP - 1);
                            state_r   <= POLL_WAIT;
                        end
`else
                        if (POLL_GAP == 0) begin
                            bus.ACIA_E   <= 1'b1;
                            bus.ACIA_CS  <= 3'b011;
                            bus.ACIA_RS  <= 1'b0;
                            bus.ACIA_RNW <= 1'b1;
                            state_r      <= POLL;
                        end else begin
                            gapCnt_r <= GW'(POLL_GAP - 1);
                            state_r  <= POLL_WAIT;
                        end
`endif
                    end
                end
                POLL_WAIT: begin
                    if (gapCnt_r == {GW{1'b0}}) begin
                        bus.ACIA_E   <= 1'b1;
                        bus.ACIA_CS  <= 3'b011;
                        bus.ACIA_RS  <= 1'b0;
                        bus.ACIA_RNW <= 1'b1;
                        state_r      <= POLL;
                    end else begin
                        gapCnt_r <= gapCnt_r - GW'(1);
                    end
                end
                WRITE: begin
                    bus.ACIA_E   <= 1'b0;
                    bus.ACIA_CS  <= 3'b000;
                    bus.ACIA_RS  <= 1'b0;
                    bus.ACIA_RNW <= 1'b1;
                    bus.ACIA_DI  <= 8'h00;
                    // TDRE lags the delayed TDR write; do not poll too early
                    gapCnt_r     <= GW'(POST_WR_GAP - 1);
                    state_r      <= GAP;
                end
                GAP: begin
                    if (gapCnt_r == {GW{1'b0}}) begin
                        bus.BUSY <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        gapCnt_r <= gapCnt_r - GW'(1);
                    end
                end
                default: begin
                    bus.ACIA_E   <= 1'b0;
                    bus.ACIA_CS  <= 3'b000;
                    bus.ACIA_RNW <= 1'b1;
                    phase_r      <= 1'b0;
                    state_r      <= INIT_MR;
                end
            endcase
        end
    end
endmodule
